// File: rtl/dcache_assoc_pkg.sv
// Shared types and helpers for the set-associative write-back data cache.
package dcache_assoc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WB     = 2'd1,
    ST_ALLOC  = 2'd2,
    ST_REFILL = 2'd3
  } cache_state_e;

  localparam int CNT_W = 32;
  localparam logic [CNT_W-1:0] CNT_MAX = 32'hFFFF_FFFF;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 32'd1;
  endfunction

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dcache_assoc_lru.sv
// Per-set age-based LRU: age update on access/fill and victim selection
// (lowest-index invalid way first, otherwise the oldest way).
module dcache_assoc_lru
  import dcache_assoc_pkg::*;
#(
  parameter int WAYS = 2,
  parameter int SETS = 16,
  localparam int IDX_W = clog2_min1(SETS),
  localparam int WAY_W = clog2_min1(WAYS)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_upd,
  input  logic             i_fill,
  input  logic [IDX_W-1:0] i_upd_set,
  input  logic [WAY_W-1:0] i_upd_way,
  input  logic [IDX_W-1:0] i_vic_set,
  input  logic [WAYS-1:0]  i_vic_valid,
  output logic [WAY_W-1:0] o_victim
);

  generate
    if (WAYS == 1) begin : g_direct
      logic w_unused_lru;
      assign w_unused_lru = &{1'b0, i_clk, i_rst, i_upd, i_fill, i_upd_set, i_upd_way,
                              i_vic_set, i_vic_valid};
      assign o_victim     = {WAY_W{1'b0}};
    end else begin : g_assoc
      logic [SETS-1:0][WAYS-1:0][WAY_W-1:0] r_age;
      logic [WAY_W-1:0] w_old_age;
      logic [WAY_W-1:0] w_inv_way;
      logic [WAY_W-1:0] w_max_way;
      logic [WAY_W-1:0] w_max_age;
      logic             w_inv_found;
      logic             w_older;

      // A freshly filled line is aged as if it had been the oldest, so ages
      // settle into a permutation even though they all start at zero.
      assign w_old_age = i_fill ? WAY_W'(WAYS - 1) : r_age[i_upd_set][i_upd_way];

      // Age update: touched way becomes youngest, younger ways grow one older.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_age <= '0;
        end else if (i_upd) begin
          for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == i_upd_way) begin
              r_age[i_upd_set][w] <= {WAY_W{1'b0}};
            end else if (r_age[i_upd_set][w] < w_old_age) begin
              r_age[i_upd_set][w] <= r_age[i_upd_set][w] + 1'b1;
            end
          end
        end
      end

      // Victim pick: first invalid way, else the way with the largest age.
      always_comb begin
        w_inv_found = 1'b0;
        w_inv_way   = {WAY_W{1'b0}};
        w_max_age   = r_age[i_vic_set][0];
        w_max_way   = {WAY_W{1'b0}};
        w_older     = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
          w_inv_way   = (!i_vic_valid[w] && !w_inv_found) ? WAY_W'(w) : w_inv_way;
          w_inv_found = w_inv_found | !i_vic_valid[w];
          w_older     = (r_age[i_vic_set][w] > w_max_age);
          w_max_way   = w_older ? WAY_W'(w) : w_max_way;
          w_max_age   = w_older ? r_age[i_vic_set][w] : w_max_age;
        end
        o_victim = w_inv_found ? w_inv_way : w_max_way;
      end
    end
  endgenerate

endmodule

// File: rtl/dcache_assoc.sv
// N-way set-associative write-back, write-allocate data cache between the
// CPU MEM stage and a line-wide data memory; stalls the pipeline on a miss.
module dcache_assoc
  import dcache_assoc_pkg::*;
#(
  parameter int WAYS      = 2,
  parameter int SETS      = 16,
  parameter int LINE_BITS = 256,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ADDR_W-1:0]    p1_addr_i,
  input  logic [DATA_W-1:0]    p1_data_i,
  input  logic                 p1_MemRead_i,
  input  logic                 p1_MemWrite_i,
  output logic [DATA_W-1:0]    p1_data_o,
  output logic                 p1_stall_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i,
  output logic [LINE_BITS-1:0] mem_data_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  output logic [CNT_W-1:0]     hit_cnt_o,
  output logic [CNT_W-1:0]     miss_cnt_o
);

  localparam int OFF   = $clog2(LINE_BITS / 8);
  localparam int IDX   = $clog2(SETS);
  localparam int TAG   = ADDR_W - IDX - OFF;
  localparam int WSEL  = OFF - 2;
  localparam int WAY_W = clog2_min1(WAYS);

  cache_state_e r_state;
  cache_state_e w_state_nxt;

  logic [TAG-1:0]            r_tag  [SETS][WAYS];
  logic [LINE_BITS-1:0]      r_data [SETS][WAYS];
  logic [SETS-1:0][WAYS-1:0] r_valid;
  logic [SETS-1:0][WAYS-1:0] r_dirty;
  logic [LINE_BITS-1:0]      r_line;
  logic [TAG-1:0]            r_req_tag;
  logic [IDX-1:0]            r_req_idx;
  logic [WAY_W-1:0]          r_victim;
  logic                      r_replay;
  logic [CNT_W-1:0]          r_hit_cnt;
  logic [CNT_W-1:0]          r_miss_cnt;

  logic [IDX-1:0]       w_idx;
  logic [TAG-1:0]       w_tag;
  logic [WSEL-1:0]      w_word;
  logic                 w_req;
  logic                 w_is_idle;
  logic [WAYS-1:0]      w_hit_vec;
  logic [WAY_W-1:0]     w_hit_way;
  logic                 w_hit;
  logic                 w_miss;
  logic                 w_store_hit;
  logic [LINE_BITS-1:0] w_hit_line;
  logic [WAY_W-1:0]     w_lru_victim;
  logic                 w_fill;
  logic                 w_upd;
  logic [IDX-1:0]       w_upd_set;
  logic [WAY_W-1:0]     w_upd_way;
  logic                 w_unused_addr;

  assign w_idx         = p1_addr_i[OFF +: IDX];
  assign w_tag         = p1_addr_i[ADDR_W-1 -: TAG];
  assign w_word        = p1_addr_i[OFF-1:2];
  assign w_unused_addr = &{1'b0, p1_addr_i[1:0]};
  assign w_req         = p1_MemRead_i | p1_MemWrite_i;
  assign w_is_idle     = (r_state == ST_IDLE);

  // Tag compare across all ways of the addressed set; lowest matching way wins.
  always_comb begin
    w_hit_vec = {WAYS{1'b0}};
    w_hit_way = {WAY_W{1'b0}};
    for (int w = WAYS - 1; w >= 0; w--) begin
      w_hit_vec[w] = r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag);
      w_hit_way    = w_hit_vec[w] ? WAY_W'(w) : w_hit_way;
    end
  end

  assign w_hit       = w_is_idle & w_req & (|w_hit_vec);
  assign w_miss      = w_is_idle & w_req & ~(|w_hit_vec);
  assign w_store_hit = w_hit & p1_MemWrite_i;
  assign w_hit_line  = r_data[w_idx][w_hit_way];

  assign p1_data_o  = w_hit ? w_hit_line[int'(w_word) * DATA_W +: DATA_W] : {DATA_W{1'b0}};
  assign p1_stall_o = ~w_is_idle | w_miss;
  assign hit_cnt_o  = r_hit_cnt;
  assign miss_cnt_o = r_miss_cnt;

  assign w_fill    = (r_state == ST_REFILL);
  assign w_upd     = w_hit | w_fill;
  assign w_upd_set = w_fill ? r_req_idx : w_idx;
  assign w_upd_way = w_fill ? r_victim : w_hit_way;

  dcache_assoc_lru #(
    .WAYS (WAYS),
    .SETS (SETS)
  ) u_lru (
    .i_clk       (clk_i),
    .i_rst       (rst_i),
    .i_upd       (w_upd),
    .i_fill      (w_fill),
    .i_upd_set   (w_upd_set),
    .i_upd_way   (w_upd_way),
    .i_vic_set   (w_idx),
    .i_vic_valid (r_valid[w_idx]),
    .o_victim    (w_lru_victim)
  );

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and memory-side request outputs.
  always_comb begin
    w_state_nxt  = r_state;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = {ADDR_W{1'b0}};
    mem_data_o   = {LINE_BITS{1'b0}};
    case (r_state)
      ST_IDLE: begin
        w_state_nxt = w_miss ? (r_dirty[w_idx][w_lru_victim] ? ST_WB : ST_ALLOC) : ST_IDLE;
      end
      ST_WB: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {r_tag[r_req_idx][r_victim], r_req_idx, {OFF{1'b0}}};
        mem_data_o   = r_data[r_req_idx][r_victim];
        w_state_nxt  = mem_ack_i ? ST_ALLOC : ST_WB;
      end
      ST_ALLOC: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {r_req_tag, r_req_idx, {OFF{1'b0}}};
        w_state_nxt  = mem_ack_i ? ST_REFILL : ST_ALLOC;
      end
      ST_REFILL: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Miss bookkeeping, valid/dirty bits and the replay flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid   <= '0;
      r_dirty   <= '0;
      r_replay  <= 1'b0;
      r_req_tag <= {TAG{1'b0}};
      r_req_idx <= {IDX{1'b0}};
      r_victim  <= {WAY_W{1'b0}};
    end else begin
      if (w_miss) begin
        r_req_tag <= w_tag;
        r_req_idx <= w_idx;
        r_victim  <= w_lru_victim;
      end
      if (w_store_hit) begin
        r_dirty[w_idx][w_hit_way] <= 1'b1;
      end
      // The replay flag only survives into the first IDLE cycle after a refill.
      if (w_fill) begin
        r_valid[r_req_idx][r_victim] <= 1'b1;
        r_dirty[r_req_idx][r_victim] <= 1'b0;
        r_replay                     <= 1'b1;
      end else if (w_is_idle) begin
        r_replay <= 1'b0;
      end
    end
  end

  // Saturating hit/miss counters; the replay hit is not counted as a hit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_hit_cnt  <= {CNT_W{1'b0}};
      r_miss_cnt <= {CNT_W{1'b0}};
    end else begin
      if (w_hit && !r_replay) begin
        r_hit_cnt <= sat_inc(r_hit_cnt);
      end
      if (w_miss) begin
        r_miss_cnt <= sat_inc(r_miss_cnt);
      end
    end
  end

  // Tag/data storage and refill buffer; contents are not cleared by reset.
  always_ff @(posedge clk_i) begin
    if ((r_state == ST_ALLOC) && mem_ack_i) begin
      r_line <= mem_data_i;
    end
    if (w_fill) begin
      r_data[r_req_idx][r_victim] <= r_line;
      r_tag[r_req_idx][r_victim]  <= r_req_tag;
    end
    if (w_store_hit) begin
      r_data[w_idx][w_hit_way][int'(w_word) * DATA_W +: DATA_W] <= p1_data_i;
    end
  end

endmodule

// File: tb/tb_dcache_assoc.sv
// Directed self-checking bench for dcache_assoc with a 10-cycle-ack memory model.
module tb_dcache_assoc;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  p1_addr_i;
  logic [31:0]  p1_data_i;
  logic         p1_MemRead_i;
  logic         p1_MemWrite_i;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;
  logic [255:0] mem_data_o;
  logic [31:0]  mem_addr_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  hit_cnt_o;
  logic [31:0]  miss_cnt_o;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0]  addr;
    logic         wr;
    logic [255:0] data;
  } req_t;

  req_t         req_q[$];
  logic [255:0] mem_wr[logic [31:0]];

  dcache_assoc dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .p1_addr_i     (p1_addr_i),
    .p1_data_i     (p1_data_i),
    .p1_MemRead_i  (p1_MemRead_i),
    .p1_MemWrite_i (p1_MemWrite_i),
    .p1_data_o     (p1_data_o),
    .p1_stall_o    (p1_stall_o),
    .mem_data_i    (mem_data_i),
    .mem_ack_i     (mem_ack_i),
    .mem_data_o    (mem_data_o),
    .mem_addr_o    (mem_addr_o),
    .mem_enable_o  (mem_enable_o),
    .mem_write_o   (mem_write_o),
    .hit_cnt_o     (hit_cnt_o),
    .miss_cnt_o    (miss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [255:0] init_line(input logic [31:0] la);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = (la + 32'(k * 4)) ^ 32'h5A5A_0000;
    return l;
  endfunction

  // Memory model: ack 10 cycles into a request, log every completed request.
  initial begin : mem_model
    int   cnt;
    bit   acked;
    req_t r;
    cnt = 0; acked = 1'b0; mem_ack_i = 1'b0; mem_data_i = '0;
    forever begin
      @(negedge clk_i);
      if (acked || rst_i || !mem_enable_o) begin
        cnt = 0; mem_ack_i = 1'b0; acked = 1'b0;
      end else begin
        cnt++;
        if (cnt == 10) begin
          r.addr = mem_addr_o; r.wr = mem_write_o; r.data = mem_data_o;
          if (mem_write_o) mem_wr[mem_addr_o] = mem_data_o;
          else mem_data_i = mem_wr.exists(mem_addr_o) ? mem_wr[mem_addr_o] : init_line(mem_addr_o);
          req_q.push_back(r);
          mem_ack_i = 1'b1; acked = 1'b1; cnt = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic access(input logic [31:0] a, input logic [31:0] d, input logic rd,
                        input logic wr, output logic [31:0] rdata, output int stalls);
    @(negedge clk_i);
    p1_addr_i = a; p1_data_i = d; p1_MemRead_i = rd; p1_MemWrite_i = wr;
    stalls = 0;
    #1;
    while (p1_stall_o === 1'b1 && stalls < 200) begin
      @(negedge clk_i); #1; stalls++;
    end
    if (stalls >= 200) begin
      n_cmp++; n_fail++;
      $display("FAIL access_timeout: addr %h stalled %0d cycles, required completion", a, stalls);
    end
    rdata = p1_data_o;
    @(posedge clk_i); #1;
    p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; p1_addr_i = '0; p1_data_i = '0; p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    n_cmp++; if (p1_stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", p1_stall_o); end
    n_cmp++; if (p1_data_o !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", p1_data_o); end
    n_cmp++; if (mem_enable_o !== 1'b0) begin n_fail++; $display("FAIL reset_enable: got %b want 0", mem_enable_o); end
    n_cmp++; if (hit_cnt_o !== 32'h0 || miss_cnt_o !== 32'h0) begin n_fail++; $display("FAIL reset_cnt: got %h/%h want 0/0", hit_cnt_o, miss_cnt_o); end
    @(negedge clk_i); rst_i = 1'b0;
    @(negedge clk_i); #1;
    n_cmp++; if (p1_stall_o !== 1'b0 || p1_data_o !== 32'h0) begin n_fail++; $display("FAIL idle_noreq: got stall %b data %h want 0/0", p1_stall_o, p1_data_o); end
  endtask

  task automatic test_cold_load();
    logic [31:0] rd; int st;
    req_q.delete();
    access(32'h100, 32'h0, 1'b1, 1'b0, rd, st);
    n_cmp++; if (st !== 12) begin n_fail++; $display("FAIL cold_stalls: got %0d want 12", st); end
    n_cmp++; if (rd !== 32'h5A5A_0100) begin n_fail++; $display("FAIL cold_data: got %h want 5a5a0100", rd); end
    n_cmp++; if (miss_cnt_o !== 32'd1 || hit_cnt_o !== 32'd0) begin n_fail++; $display("FAIL cold_cnt: got %0d/%0d want 0/1", hit_cnt_o, miss_cnt_o); end
    n_cmp++; if (req_q.size() !== 1) begin n_fail++; $display("FAIL cold_nreq: got %0d want 1", req_q.size()); end
    else if (req_q[0].addr !== 32'h100 || req_q[0].wr !== 1'b0) begin n_fail++; n_cmp++; $display("FAIL cold_req: got %h/%b want 00000100/0", req_q[0].addr, req_q[0].wr); end
  endtask

  task automatic test_store_load_hit();
    logic [31:0] rd; int st;
    access(32'h104, 32'hDEAD_BEEF, 1'b0, 1'b1, rd, st);
    n_cmp++; if (st !== 0) begin n_fail++; $display("FAIL store_hit_stall: got %0d want 0", st); end
    access(32'h104, 32'h0, 1'b1, 1'b0, rd, st);
    n_cmp++; if (st !== 0 || rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL load_hit: got %0d/%h want 0/deadbeef", st, rd); end
    n_cmp++; if (hit_cnt_o !== 32'd2) begin n_fail++; $display("FAIL hit_cnt2: got %0d want 2", hit_cnt_o); end
  endtask

  task automatic test_lru_evict();
    logic [31:0] rd; int st;
    access(32'h100, 32'h0, 1'b1, 1'b0, rd, st);
    n_cmp++; if (st !== 0 || rd !== 32'h5A5A_0100 || hit_cnt_o !== 32'd3) begin n_fail++; $display("FAIL lru_hit100: got %0d/%h/%0d want 0/5a5a0100/3", st, rd, hit_cnt_o); end
    req_q.delete();
    access(32'h300, 32'h0, 1'b1, 1'b0, rd, st);
    n_cmp++; if (st !== 12 || rd !== 32'h5A5A_0300 || miss_cnt_o !== 32'd2) begin n_fail++; $display("FAIL lru_miss300: got %0d/%h/%0d want 12/5a5a0300/2", st, rd, miss_cnt_o); end
    n_cmp++; if (req_q.size() !== 1) begin n_fail++; $display("FAIL lru_nreq300: got %0d want 1", req_q.size()); end
    req_q.delete();
    access(32'h500, 32'h0, 1'b1, 1'b0, rd, st);
    n_cmp++; if (st !== 23 || rd !== 32'h5A5A_0500 || miss_cnt_o !== 32'd3) begin n_fail++; $display("FAIL lru_miss500: got %0d/%h/%0d want 23/5a5a0500/3", st, rd, miss_cnt_o); end
    n_cmp++;
    if (req_q.size() !== 2) begin n_fail++; $display("FAIL wb_nreq: got %0d want 2", req_q.size()); end
    else begin
      if (req_q[0].addr !== 32'h100 || req_q[0].wr !== 1'b1) begin n_fail++; $display("FAIL wb_req: got %h/%b want 00000100/1", req_q[0].addr, req_q[0].wr); end
      n_cmp++; if (req_q[0].data[63:0] !== 64'hDEAD_BEEF_5A5A_0100) begin n_fail++; $display("FAIL wb_data: got %h want deadbeef5a5a0100", req_q[0].data[63:0]); end
      n_cmp++; if (req_q[1].addr !== 32'h500 || req_q[1].wr !== 1'b0) begin n_fail++; $display("FAIL alloc500: got %h/%b want 00000500/0", req_q[1].addr, req_q[1].wr); end
    end
    access(32'h300, 32'h0, 1'b1, 1'b0, rd, st);
    n_cmp++; if (st !== 0 || rd !== 32'h5A5A_0300 || hit_cnt_o !== 32'd4) begin n_fail++; $display("FAIL reload300: got %0d/%h/%0d want 0/5a5a0300/4", st, rd, hit_cnt_o); end
  endtask

  task automatic test_writeback_roundtrip();
    logic [31:0] rd; int st;
    req_q.delete();
    access(32'h104, 32'h0, 1'b1, 1'b0, rd, st);
    n_cmp++; if (st !== 12 || rd !== 32'hDEAD_BEEF || miss_cnt_o !== 32'd4) begin n_fail++; $display("FAIL roundtrip: got %0d/%h/%0d want 12/deadbeef/4", st, rd, miss_cnt_o); end
    n_cmp++; if (req_q.size() !== 1) begin n_fail++; $display("FAIL roundtrip_nreq: got %0d want 1", req_q.size()); end
  endtask

  task automatic test_reset_mid_miss();
    logic [31:0] rd; int st;
    @(negedge clk_i);
    p1_addr_i = 32'h700; p1_MemRead_i = 1'b1;
    repeat (3) @(negedge clk_i);
    #1;
    n_cmp++; if (mem_enable_o !== 1'b1 || mem_write_o !== 1'b0 || mem_addr_o !== 32'h700) begin n_fail++; $display("FAIL mid_alloc: got %b/%b/%h want 1/0/00000700", mem_enable_o, mem_write_o, mem_addr_o); end
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    n_cmp++; if (mem_enable_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_enable: got %b want 0", mem_enable_o); end
    n_cmp++; if (hit_cnt_o !== 32'd0 || miss_cnt_o !== 32'd0) begin n_fail++; $display("FAIL mid_rst_cnt: got %0d/%0d want 0/0", hit_cnt_o, miss_cnt_o); end
    p1_MemRead_i = 1'b0;
    @(negedge clk_i); rst_i = 1'b0;
    access(32'h100, 32'h0, 1'b1, 1'b0, rd, st);
    n_cmp++; if (st !== 12 || rd !== 32'h5A5A_0100 || miss_cnt_o !== 32'd1) begin n_fail++; $display("FAIL post_rst_miss: got %0d/%h/%0d want 12/5a5a0100/1", st, rd, miss_cnt_o); end
    access(32'h104, 32'h0, 1'b1, 1'b0, rd, st);
    n_cmp++; if (st !== 0 || rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL post_rst_hit: got %0d/%h want 0/deadbeef", st, rd); end
  endtask

  task automatic test_rw_both();
    logic [31:0] rd; int st;
    access(32'h108, 32'h1234_5678, 1'b1, 1'b1, rd, st);
    n_cmp++; if (st !== 0) begin n_fail++; $display("FAIL both_stall: got %0d want 0", st); end
    access(32'h108, 32'h0, 1'b1, 1'b0, rd, st);
    n_cmp++; if (rd !== 32'h1234_5678 || hit_cnt_o !== 32'd3) begin n_fail++; $display("FAIL both_store: got %h/%0d want 12345678/3", rd, hit_cnt_o); end
  endtask

  task automatic test_saturation();
    logic [31:0] rd; int st;
    @(negedge clk_i);
    force dut.r_miss_cnt = 32'hFFFF_FFFE;
    @(negedge clk_i);
    release dut.r_miss_cnt;
    access(32'h900, 32'h0, 1'b1, 1'b0, rd, st);
    n_cmp++; if (miss_cnt_o !== 32'hFFFF_FFFF || rd !== 32'h5A5A_0900) begin n_fail++; $display("FAIL sat_first: got %h/%h want ffffffff/5a5a0900", miss_cnt_o, rd); end
    req_q.delete();
    access(32'hB00, 32'h0, 1'b1, 1'b0, rd, st);
    n_cmp++; if (miss_cnt_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat_hold: got %h want ffffffff", miss_cnt_o); end
    n_cmp++; if (st !== 23 || rd !== 32'h5A5A_0B00) begin n_fail++; $display("FAIL sat_wb_miss: got %0d/%h want 23/5a5a0b00", st, rd); end
    n_cmp++;
    if (req_q.size() !== 2) begin n_fail++; $display("FAIL sat_nreq: got %0d want 2", req_q.size()); end
    else if (req_q[0].addr !== 32'h100 || req_q[0].data[95:64] !== 32'h1234_5678) begin n_fail++; $display("FAIL sat_wb: got %h/%h want 00000100/12345678", req_q[0].addr, req_q[0].data[95:64]); end
  endtask

  initial begin
    test_reset();
    test_cold_load();
    test_store_load_hit();
    test_lru_evict();
    test_writeback_roundtrip();
    test_reset_mid_miss();
    test_rw_both();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
